// File: rtl/text_writer_if.sv
// Byte-stream input plus VRAM write port and cursor/scroll outputs of the text writer.
// master = byte source, slave = the writer itself.
interface text_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       vram_we;
    logic [4:0] vram_wrow;
    logic [6:0] vram_wcol;
    logic [7:0] vram_wbyte;
    logic [4:0] top_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    modport master (
        output in_valid, in_byte,
        input  in_ready, vram_we, vram_wrow, vram_wcol, vram_wbyte,
               top_row, cursor_row, cursor_col
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, vram_we, vram_wrow, vram_wcol, vram_wbyte,
               top_row, cursor_row, cursor_col
    );
endinterface

// File: rtl/text_writer.sv
// Writes a terminal byte stream into the circular character VRAM, tracking the cursor,
// handling CR/LF/BS/FF, and scrolling by advancing top_row and blanking the recycled row.
module text_writer #(
    parameter int         COLS  = 100,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic           clk,
    input  logic           reset,
    text_writer_if.slave   bus
);
    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     r_state,   w_state_n;
    logic [4:0] r_clr_row, w_clr_row_n;
    logic [6:0] r_clr_col, w_clr_col_n;
    logic       r_we,      w_we_n;
    logic [4:0] r_wrow,    w_wrow_n;
    logic [6:0] r_wcol,    w_wcol_n;
    logic [7:0] r_wbyte,   w_wbyte_n;
    logic [4:0] r_top,     w_top_n;
    logic [4:0] r_crow,    w_crow_n;
    logic [6:0] r_ccol,    w_ccol_n;
    logic [4:0] r_line,    w_line_n;
    logic       w_printable;
    logic       w_lf;

    assign w_printable = (bus.in_byte >= 8'h20) && (bus.in_byte != 8'h7F);

    always_ff @(posedge clk) begin
        if (reset) r_state <= CLEAR_ALL;
        else       r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_row <= '0;
            r_clr_col <= '0;
            r_we      <= 1'b0;
            r_wrow    <= '0;
            r_wcol    <= '0;
            r_wbyte   <= '0;
            r_top     <= '0;
            r_crow    <= '0;
            r_ccol    <= '0;
            r_line    <= '0;
        end else begin
            r_clr_row <= w_clr_row_n;
            r_clr_col <= w_clr_col_n;
            r_we      <= w_we_n;
            r_wrow    <= w_wrow_n;
            r_wcol    <= w_wcol_n;
            r_wbyte   <= w_wbyte_n;
            r_top     <= w_top_n;
            r_crow    <= w_crow_n;
            r_ccol    <= w_ccol_n;
            r_line    <= w_line_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_clr_row_n = r_clr_row;
        w_clr_col_n = r_clr_col;
        w_we_n      = 1'b0;
        w_wrow_n    = r_wrow;
        w_wcol_n    = r_wcol;
        w_wbyte_n   = r_wbyte;
        w_top_n     = r_top;
        w_crow_n    = r_crow;
        w_ccol_n    = r_ccol;
        w_line_n    = r_line;
        w_lf        = 1'b0;

        case (r_state)
            CLEAR_ALL: begin
                w_we_n    = 1'b1;
                w_wrow_n  = r_clr_row;
                w_wcol_n  = r_clr_col;
                w_wbyte_n = BLANK;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_n = '0;
                    if (r_clr_row == LAST_ROW) begin
                        w_clr_row_n = '0;
                        w_state_n   = IDLE;
                    end else begin
                        w_clr_row_n = r_clr_row + 5'd1;
                    end
                end else begin
                    w_clr_col_n = r_clr_col + 7'd1;
                end
            end

            // The row being blanked is the one the cursor now sits on after the scroll.
            CLEAR_LINE: begin
                w_we_n    = 1'b1;
                w_wrow_n  = r_crow;
                w_wcol_n  = r_clr_col;
                w_wbyte_n = BLANK;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_n = '0;
                    w_state_n   = IDLE;
                end else begin
                    w_clr_col_n = r_clr_col + 7'd1;
                end
            end

            IDLE: begin
                if (bus.in_valid) begin
                    if (w_printable) begin
                        w_we_n    = 1'b1;
                        w_wrow_n  = r_crow;
                        w_wcol_n  = r_ccol;
                        w_wbyte_n = bus.in_byte;
                        if (r_ccol < LAST_COL) begin
                            w_ccol_n = r_ccol + 7'd1;
                        end else begin
                            w_ccol_n = '0;
                            w_lf     = 1'b1;
                        end
                    end else begin
                        case (bus.in_byte)
                            8'h0D: w_ccol_n = '0;
                            8'h0A: w_lf     = 1'b1;
                            8'h08: if (r_ccol != '0) w_ccol_n = r_ccol - 7'd1;
                            8'h0C: begin
                                w_top_n     = '0;
                                w_crow_n    = '0;
                                w_ccol_n    = '0;
                                w_line_n    = '0;
                                w_clr_row_n = '0;
                                w_clr_col_n = '0;
                                w_state_n   = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: w_state_n = CLEAR_ALL;
        endcase

        // Line feed: move down, or on the bottom line recycle the old top row as the new bottom.
        if (w_lf) begin
            if (r_line < LAST_ROW) begin
                w_line_n = r_line + 5'd1;
                w_crow_n = (r_crow == LAST_ROW) ? 5'd0 : r_crow + 5'd1;
            end else begin
                w_top_n     = (r_top == LAST_ROW) ? 5'd0 : r_top + 5'd1;
                w_crow_n    = r_top;
                w_clr_col_n = '0;
                w_state_n   = CLEAR_LINE;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.vram_we    = r_we;
    assign bus.vram_wrow  = r_wrow;
    assign bus.vram_wcol  = r_wcol;
    assign bus.vram_wbyte = r_wbyte;
    assign bus.top_row    = r_top;
    assign bus.cursor_row = r_crow;
    assign bus.cursor_col = r_ccol;
endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: directed scenarios then random bytes, compared
// against a screen-level model (top/line/col) and an expected VRAM write queue.
module tb_text_writer;
    localparam int COLS = 100;
    localparam int ROWS = 30;

    logic clk = 1'b0;
    logic reset;

    text_writer_if tif ();

    text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
        bit contig;
        bit busy;
    } wr_t;

    wr_t expQ[$];
    int  checks    = 0;
    int  errors    = 0;
    int  cyc       = 0;
    int  lastWrCyc = -10;
    int  prevWrCyc = -10;
    int  wrCount   = 0;
    int  mdlTop, mdlLine, mdlCol;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void pushWrite(int r, int c, int d, bit contig, bit busy);
        wr_t e;
        e.row = r; e.col = c; e.data = d; e.contig = contig; e.busy = busy;
        expQ.push_back(e);
    endfunction

    function automatic void modelReset();
        mdlTop = 0; mdlLine = 0; mdlCol = 0;
    endfunction

    // Whole screen blanked row-major; the final write already shows in_ready high.
    function automatic void pushClearAll();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pushWrite(r, c, 32'h20, !(r == 0 && c == 0), !(r == ROWS-1 && c == COLS-1));
    endfunction

    function automatic void modelLf(bit afterChar);
        if (mdlLine < ROWS-1) begin
            mdlLine++;
        end else begin
            mdlTop = (mdlTop + 1) % ROWS;
            for (int c = 0; c < COLS; c++)
                pushWrite((mdlTop + mdlLine) % ROWS, c, 32'h20, (c > 0) || afterChar, c < COLS-1);
        end
    endfunction

    function automatic void modelByte(logic [7:0] b);
        if (b >= 8'h20 && b != 8'h7F) begin
            pushWrite((mdlTop + mdlLine) % ROWS, mdlCol, int'(b), 1'b0, 1'b0);
            if (mdlCol < COLS-1) begin
                mdlCol++;
            end else begin
                mdlCol = 0;
                modelLf(1'b1);
            end
        end else begin
            case (b)
                8'h0D: mdlCol = 0;
                8'h0A: modelLf(1'b0);
                8'h08: if (mdlCol > 0) mdlCol--;
                8'h0C: begin
                    modelReset();
                    pushClearAll();
                end
                default: ;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (tif.vram_we === 1'b1) begin
            wrCount++;
            prevWrCyc = lastWrCyc;
            lastWrCyc = cyc;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_row",  32'(tif.vram_wrow),  e.row);
                checkOutput("wr_col",  32'(tif.vram_wcol),  e.col);
                checkOutput("wr_data", 32'(tif.vram_wbyte), e.data);
                if (e.contig) checkOutput("wr_contig", cyc - prevWrCyc, 32'd1);
                if (e.busy)   checkOutput("wr_busy_ready", 32'(tif.in_ready), 32'd0);
            end
        end
    end

    task automatic checkCursor(input string tag);
        checkOutput({tag, "_top"},  32'(tif.top_row),    mdlTop);
        checkOutput({tag, "_crow"}, 32'(tif.cursor_row), (mdlTop + mdlLine) % ROWS);
        checkOutput({tag, "_ccol"}, 32'(tif.cursor_col), mdlCol);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (tif.in_ready !== 1'b1 && n < budget);
        checkOutput("idle_reached", 32'(tif.in_ready), 32'd1);
    endtask

    // Presents one byte, holding in_valid while the writer is busy, then checks the cursor.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk); #1;
        tif.in_valid = 1'b1;
        tif.in_byte  = b;
        while (tif.in_ready !== 1'b1 && n < 4000) begin
            @(negedge clk); #1;
            n++;
        end
        if (tif.in_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            tif.in_valid = 1'b0;
        end else begin
            modelByte(b);
            @(posedge clk); #1;
            tif.in_valid = 1'b0;
            checkCursor("cursor");
        end
    endtask

    function automatic logic [7:0] randomByte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 999);
        if (r < 3)        b = 8'h0C;
        else if (r < 550) begin
            b = 8'($urandom_range(32, 255));
            if (b == 8'h7F) b = 8'h41;
        end
        else if (r < 700) b = 8'h0A;
        else if (r < 780) b = 8'h0D;
        else if (r < 880) b = 8'h08;
        else if (r < 950) b = 8'($urandom_range(0, 31));
        else              b = 8'h7F;
        return b;
    endfunction

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        tif.in_valid = 1'b0;
        tif.in_byte  = 8'h00;
        reset        = 1'b1;
        modelReset();

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("rst_we",    32'(tif.vram_we),  32'd0);
        checkOutput("rst_ready", 32'(tif.in_ready), 32'd0);
        checkCursor("rst");

        pushClearAll();
        base  = wrCount;
        reset = 1'b0;
        waitIdle(3100);
        checkOutput("init_count", wrCount - base, 32'd3000);
        checkOutput("init_drained", expQ.size(), 32'd0);
        checkCursor("init");

        applyStimulus(8'h41);
        applyStimulus(8'h42);
        @(negedge clk); #1;
        checkOutput("b2b_gap", lastWrCyc - prevWrCyc, 32'd1);
        checkOutput("b2b_ready", 32'(tif.in_ready), 32'd1);
        checkOutput("b2b_col", 32'(tif.cursor_col), 32'd2);

        repeat (3) applyStimulus(8'h43);
        applyStimulus(8'h08);
        checkOutput("bs_col", 32'(tif.cursor_col), 32'd4);
        applyStimulus(8'h0D);
        applyStimulus(8'h08);
        checkOutput("bs_at0_col", 32'(tif.cursor_col), 32'd0);
        applyStimulus(8'h0A);
        checkOutput("lf_row", 32'(tif.cursor_row), 32'd1);
        applyStimulus(8'h07);

        applyStimulus(8'h0C);
        waitIdle(3100);
        repeat (101) applyStimulus(8'h58);
        checkOutput("wrap_row", 32'(tif.cursor_row), 32'd1);
        checkOutput("wrap_col", 32'(tif.cursor_col), 32'd1);

        applyStimulus(8'h0C);
        waitIdle(3100);
        repeat (29) applyStimulus(8'h0A);
        checkOutput("lf29_row", 32'(tif.cursor_row), 32'd29);
        applyStimulus(8'h0A);
        checkOutput("scroll_top", 32'(tif.top_row), 32'd1);
        checkOutput("scroll_row", 32'(tif.cursor_row), 32'd0);
        waitIdle(200);
        applyStimulus(8'h0A);
        checkOutput("scroll2_top", 32'(tif.top_row), 32'd2);
        waitIdle(200);
        repeat (3) begin
            applyStimulus(8'h0A);
            waitIdle(200);
        end
        checkOutput("top5", 32'(tif.top_row), 32'd5);

        applyStimulus(8'h0C);
        base = wrCount;
        n    = 0;
        while (wrCount - base < 50 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("clr50_reached", wrCount - base, 32'd50);
        reset = 1'b1;
        expQ.delete();
        modelReset();
        @(posedge clk); #1;
        checkOutput("midrst_we", 32'(tif.vram_we), 32'd0);
        @(negedge clk); #1;
        checkOutput("midrst_ready", 32'(tif.in_ready), 32'd0);
        checkCursor("midrst");
        pushClearAll();
        base  = wrCount;
        reset = 1'b0;
        waitIdle(3100);
        checkOutput("rerun_count", wrCount - base, 32'd3000);

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(randomByte());
        end

        waitIdle(3100);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("final_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
